imem_fetch_responder: RTL and testbench

//  Instruction-memory responder at the far end of the IF-stage fetch interface. Takes PC fetch

---
 rtl/imem_fetch_responder.sv | 172 +++++++++++++++++
 tb/tb_imem_fetch_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the IF-stage fetch port: a fixed-latency read pipeline,
// a response FIFO with credit-based request admission, IF flush, and a test preload port.
module imem_fetch_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  IM_inREQVALID,
    input  logic [31:0]           IM_inREQADDR,
    output logic                  IM_outREQREADY,
    input  logic                  IM_inFLUSH,
    output logic                  IM_outRSPVALID,
    output logic [31:0]           IM_outRSPINST,
    output logic [31:0]           IM_outRSPADDR,
    output logic                  IM_outRSPERR,
    input  logic                  IM_inRSPREADY,
    input  logic                  IM_inLOADEN,
    input  logic [DEPTH_LOG2-1:0] IM_inLOADADDR,
    input  logic [31:0]           IM_inLOADDATA
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = PW + 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]   OUT_MAX = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [CW-1:0]           r_outstanding;
    logic [LATENCY-1:0]      r_pvld;
    logic [LATENCY-1:0]      r_perr;
    logic [31:0]             r_paddr [0:LATENCY-1];
    logic [31:0]             r_pdata [0:LATENCY-1];
    logic [31:0]             r_fdata [0:FIFO_DEPTH-1];
    logic [31:0]             r_faddr [0:FIFO_DEPTH-1];
    logic [FIFO_DEPTH-1:0]   r_ferr;
    logic [PTRW-1:0]         r_wptr;
    logic [PTRW-1:0]         r_rptr;

    logic                    w_mem_we;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_empty;
    logic                    w_req_err;
    logic [DEPTH_LOG2-1:0]   w_req_idx;

    assign w_req_idx = IM_inREQADDR[DEPTH_LOG2+1:2];
    assign w_req_err = (|IM_inREQADDR[1:0]) || (|IM_inREQADDR[31:DEPTH_LOG2+2]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_accept  = IM_inREQVALID && IM_outREQREADY;
    assign w_pop     = IM_outRSPVALID && IM_inRSPREADY;

    // FSM state register
    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: LOAD may only be entered once every credit has been returned
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (IM_inLOADEN && (r_outstanding == '0)) w_state_nxt = ST_LOAD;
                else                                     w_state_nxt = ST_RUN;
            end
            ST_LOAD: begin
                if (IM_inLOADEN) w_state_nxt = ST_LOAD;
                else             w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: request admission and preload write strobe (the LOAD entry cycle writes too)
    always_comb begin
        IM_outREQREADY = 1'b0;
        w_mem_we       = 1'b0;
        case (r_state)
            ST_RUN: begin
                IM_outREQREADY = (r_outstanding < OUT_MAX) && !IM_inFLUSH && !IM_inLOADEN && !RESET;
                w_mem_we       = IM_inLOADEN && (r_outstanding == '0) && !RESET;
            end
            ST_LOAD: begin
                IM_outREQREADY = 1'b0;
                w_mem_we       = IM_inLOADEN && !RESET;
            end
            default: begin
                IM_outREQREADY = 1'b0;
                w_mem_we       = 1'b0;
            end
        endcase
    end

    // Instruction array write port
    always_ff @(posedge CLOCK) begin
        if (w_mem_we) r_mem[IM_inLOADADDR] <= IM_inLOADDATA;
    end

    // Pipeline valid bits; a flush kills everything in flight
    always_ff @(posedge CLOCK) begin
        if (RESET || IM_inFLUSH) begin
            r_pvld <= '0;
        end else begin
            r_pvld[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) r_pvld[i] <= r_pvld[i-1];
        end
    end

    // Pipeline payload: stage 1 is the synchronous array read, later stages are delays
    always_ff @(posedge CLOCK) begin
        if (w_accept) begin
            r_pdata[0] <= r_mem[w_req_idx];
            r_paddr[0] <= IM_inREQADDR;
            r_perr[0]  <= w_req_err;
        end
        for (int i = 1; i < LATENCY; i++) begin
            r_pdata[i] <= r_pdata[i-1];
            r_paddr[i] <= r_paddr[i-1];
            r_perr[i]  <= r_perr[i-1];
        end
    end

    // Response FIFO storage; faulting fetches return a NOP word
    always_ff @(posedge CLOCK) begin
        if (r_pvld[LATENCY-1]) begin
            r_fdata[r_wptr[PW-1:0]] <= r_perr[LATENCY-1] ? 32'h0000_0000 : r_pdata[LATENCY-1];
            r_faddr[r_wptr[PW-1:0]] <= r_paddr[LATENCY-1];
            r_ferr[r_wptr[PW-1:0]]  <= r_perr[LATENCY-1];
        end
    end

    // FIFO pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge CLOCK) begin
        if (RESET || IM_inFLUSH) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (r_pvld[LATENCY-1]) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)             r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Credit counter: bounds in-flight plus buffered responses to the FIFO capacity
    always_ff @(posedge CLOCK) begin
        if (RESET || IM_inFLUSH)      r_outstanding <= '0;
        else if (w_accept && !w_pop)  r_outstanding <= r_outstanding + CNT_ONE;
        else if (!w_accept && w_pop)  r_outstanding <= r_outstanding - CNT_ONE;
        else                          r_outstanding <= r_outstanding;
    end

    assign IM_outRSPVALID = !w_empty && !IM_inFLUSH && !RESET;

    // First-word-fall-through head, zeroed when nothing is presented
    always_comb begin
        if (IM_outRSPVALID) begin
            IM_outRSPINST = r_fdata[r_rptr[PW-1:0]];
            IM_outRSPADDR = r_faddr[r_rptr[PW-1:0]];
            IM_outRSPERR  = r_ferr[r_rptr[PW-1:0]];
        end else begin
            IM_outRSPINST = 32'h0000_0000;
            IM_outRSPADDR = 32'h0000_0000;
            IM_outRSPERR  = 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: a queue-based reference model predicts
// admission, response timing and content; each scenario task checks the DUT against it.
module tb_imem_fetch_responder;
    localparam int DL  = 10;
    localparam int LAT = 2;
    localparam int FD  = 4;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          IM_inREQVALID = 1'b0;
    logic [31:0]   IM_inREQADDR = 32'h0;
    logic          IM_outREQREADY;
    logic          IM_inFLUSH = 1'b0;
    logic          IM_outRSPVALID;
    logic [31:0]   IM_outRSPINST;
    logic [31:0]   IM_outRSPADDR;
    logic          IM_outRSPERR;
    logic          IM_inRSPREADY = 1'b1;
    logic          IM_inLOADEN = 1'b0;
    logic [DL-1:0] IM_inLOADADDR = '0;
    logic [31:0]   IM_inLOADDATA = 32'h0;

    imem_fetch_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IM_inREQVALID(IM_inREQVALID), .IM_inREQADDR(IM_inREQADDR), .IM_outREQREADY(IM_outREQREADY),
        .IM_inFLUSH(IM_inFLUSH),
        .IM_outRSPVALID(IM_outRSPVALID), .IM_outRSPINST(IM_outRSPINST), .IM_outRSPADDR(IM_outRSPADDR),
        .IM_outRSPERR(IM_outRSPERR), .IM_inRSPREADY(IM_inRSPREADY),
        .IM_inLOADEN(IM_inLOADEN), .IM_inLOADADDR(IM_inLOADADDR), .IM_inLOADDATA(IM_inLOADDATA)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct { logic [31:0] addr; logic [31:0] inst; logic err; int t; } rsp_t;
    rsp_t        q[$];
    logic [31:0] m_mem [0:(1<<DL)-1];
    int          m_outst = 0;
    bit          m_load  = 1'b0;
    int          cyc     = 0;
    int          n_chk   = 0;
    int          n_fail  = 0;

    function automatic bit exp_ready();
        return !RESET && !m_load && (m_outst < FD) && !IM_inFLUSH && !IM_inLOADEN;
    endfunction

    function automatic bit exp_rv();
        return !RESET && !IM_inFLUSH && (q.size() > 0) && (q[0].t <= cyc);
    endfunction

    function automatic logic [64:0] exp_head();
        return {q[0].inst, q[0].addr, q[0].err};
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit rdy, rv, acc, pop;
        int o0;
        rsp_t r;
        logic [31:0] a;
        rdy = exp_ready();
        rv  = exp_rv();
        acc = IM_inREQVALID && rdy;
        pop = rv && IM_inRSPREADY;
        o0  = m_outst;
        a   = IM_inREQADDR;
        if (!RESET && IM_inLOADEN && (m_load || o0 == 0)) m_mem[IM_inLOADADDR] = IM_inLOADDATA;
        if (RESET)       m_load = 1'b0;
        else if (m_load) m_load = IM_inLOADEN;
        else             m_load = IM_inLOADEN && (o0 == 0);
        if (RESET || IM_inFLUSH) begin
            q.delete();
            m_outst = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                r.addr = a;
                r.err  = (a[1:0] != 2'b00) || (a[31:DL+2] != 0);
                r.inst = r.err ? 32'h0 : m_mem[a[DL+1:2]];
                r.t    = cyc + 1 + LAT;
                q.push_back(r);
            end
            m_outst = o0 + int'(acc) - int'(pop);
        end
        @(posedge CLOCK);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        IM_inREQVALID = 1'b0; IM_inFLUSH = 1'b0; IM_inLOADEN = 1'b0; IM_inRSPREADY = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; idle_inputs();
        tick();
        IM_inREQVALID = 1'b1;
        #1;
        if ({IM_outREQREADY, IM_outRSPVALID, IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== 67'h0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", {IM_outREQREADY, IM_outRSPVALID, IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR});
        end
        n_chk++;
        tick();
        RESET = 1'b0; IM_inREQVALID = 1'b0;
        #1;
        if (IM_outREQREADY !== 1'b1 || IM_outRSPVALID !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got rdy=%b rv=%b exp rdy=1 rv=0", IM_outREQREADY, IM_outRSPVALID);
        end
        n_chk++;
    endtask

    task automatic test_preload();
        idle_inputs();
        IM_inLOADEN = 1'b1;
        for (int i = 0; i < 64; i++) begin
            IM_inLOADADDR = DL'(i); IM_inLOADDATA = $urandom;
            #1;
            if (IM_outREQREADY !== 1'b0) begin n_fail++; $display("FAIL preload_ready i=%0d got=%b exp=0", i, IM_outREQREADY); end
            n_chk++;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int first_acc, first_rv, pops;
        first_acc = -1; first_rv = -1; pops = 0;
        for (int i = 0; i < 12; i++) begin
            IM_inREQVALID = (i < 4); IM_inREQADDR = 32'(4 * i); IM_inRSPREADY = 1'b1;
            #1;
            if (IM_outREQREADY !== exp_ready()) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, IM_outREQREADY, exp_ready()); end
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL b2b_rspvalid cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk += 2;
            if (exp_rv()) begin
                if ({IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== exp_head()) begin
                    n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, {IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR}, exp_head());
                end
                n_chk++;
            end
            if (IM_inREQVALID && IM_outREQREADY && first_acc < 0) first_acc = cyc;
            if (IM_outRSPVALID && first_rv < 0) first_rv = cyc;
            if (IM_outRSPVALID) pops++;
            tick();
        end
        if (first_rv - (first_acc + 1) != LAT) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", first_rv - (first_acc + 1), LAT); end
        if (pops != 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", pops); end
        n_chk += 2;
    endtask

    task automatic test_stall();
        int accepts, pops;
        accepts = 0; pops = 0;
        for (int i = 0; i < 18; i++) begin
            IM_inREQVALID = (i < 8); IM_inREQADDR = 32'(4 * (8 + i)); IM_inRSPREADY = (i >= 9);
            #1;
            if (IM_outREQREADY !== exp_ready()) begin n_fail++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, IM_outREQREADY, exp_ready()); end
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL stall_rspvalid cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk += 2;
            if (exp_rv()) begin
                if ({IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== exp_head()) begin
                    n_fail++; $display("FAIL stall_head cyc=%0d got=%h exp=%h", cyc, {IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR}, exp_head());
                end
                n_chk++;
            end
            if (IM_inREQVALID && IM_outREQREADY) accepts++;
            if (IM_outRSPVALID && IM_inRSPREADY) pops++;
            tick();
        end
        if (accepts != FD) begin n_fail++; $display("FAIL stall_accepts got=%0d exp=%0d", accepts, FD); end
        if (pops != FD) begin n_fail++; $display("FAIL stall_pops got=%0d exp=%0d", pops, FD); end
        n_chk += 2;
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            IM_inREQVALID = (i == 0 || i == 1 || i == 3);
            IM_inREQADDR  = (i == 3) ? 32'h40 : 32'(32'h20 + 4 * i);
            IM_inFLUSH    = (i == 2);
            #1;
            if (IM_outREQREADY !== exp_ready()) begin n_fail++; $display("FAIL flush_ready cyc=%0d got=%b exp=%b", cyc, IM_outREQREADY, exp_ready()); end
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL flush_rspvalid cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk += 2;
            if (IM_outRSPVALID) begin
                seen++;
                if (IM_outRSPINST !== m_mem[16] || IM_outRSPADDR !== 32'h40) begin
                    n_fail++; $display("FAIL flush_data got=%h/%h exp=%h/00000040", IM_outRSPINST, IM_outRSPADDR, m_mem[16]);
                end
                n_chk++;
            end
            tick();
        end
        if (seen != 1) begin n_fail++; $display("FAIL flush_count got=%0d exp=1", seen); end
        n_chk++;
    endtask

    task automatic test_error();
        logic [31:0] addrs [4];
        int errs;
        addrs[0] = 32'h2; addrs[1] = 32'(1 << (DL + 2)); addrs[2] = 32'h8; addrs[3] = 32'h3;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            IM_inREQVALID = (i < 4); IM_inREQADDR = addrs[i % 4];
            #1;
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL err_rspvalid cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk++;
            if (exp_rv()) begin
                if ({IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== exp_head()) begin
                    n_fail++; $display("FAIL err_data cyc=%0d got=%h exp=%h", cyc, {IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR}, exp_head());
                end
                n_chk++;
            end
            if (IM_outRSPVALID && IM_outRSPERR) errs++;
            tick();
        end
        if (errs != 3) begin n_fail++; $display("FAIL err_count got=%0d exp=3", errs); end
        n_chk++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            idle_inputs(); IM_inRSPREADY = 1'b0; IM_inREQVALID = 1'b1; IM_inREQADDR = 32'(4 * i);
            tick();
        end
        RESET = 1'b1;
        #1;
        if (IM_outREQREADY !== 1'b0 || IM_outRSPVALID !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_cycle got rdy=%b rv=%b exp 0/0", IM_outREQREADY, IM_outRSPVALID);
        end
        n_chk++;
        tick();
        RESET = 1'b0; idle_inputs();
        #1;
        if ({IM_outRSPVALID, IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== 66'h0 || IM_outREQREADY !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_after got rv/data=%h rdy=%b exp 0 rdy=1", {IM_outRSPVALID, IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR}, IM_outREQREADY);
        end
        n_chk++;
        for (int i = 0; i < 6; i++) begin
            IM_inREQVALID = (i == 0); IM_inREQADDR = 32'h0;
            #1;
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL rstmid_rv cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk++;
            if (exp_rv()) begin
                if (IM_outRSPINST !== m_mem[0]) begin n_fail++; $display("FAIL rstmid_reread got=%h exp=%h", IM_outRSPINST, m_mem[0]); end
                n_chk++;
            end
            tick();
        end
    endtask

    task automatic test_load_busy();
        logic [31:0] d;
        int hit;
        d = $urandom; hit = 0;
        for (int i = 0; i < 24; i++) begin
            idle_inputs();
            IM_inREQVALID = (i < 2) || (i == 14) || (i == 15);
            IM_inREQADDR  = (i < 2) ? 32'(4 * i) : ((i == 14) ? 32'h18 : 32'h14);
            IM_inRSPREADY = (i >= 5);
            IM_inLOADEN   = (i >= 2 && i < 13);
            IM_inLOADADDR = (i < 5) ? DL'(6) : DL'(5);
            IM_inLOADDATA = (i < 5) ? ~d : d;
            #1;
            if (IM_outREQREADY !== exp_ready()) begin n_fail++; $display("FAIL load_ready cyc=%0d got=%b exp=%b", cyc, IM_outREQREADY, exp_ready()); end
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL load_rspvalid cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk += 2;
            if (exp_rv()) begin
                if ({IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== exp_head()) begin
                    n_fail++; $display("FAIL load_data cyc=%0d got=%h exp=%h", cyc, {IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR}, exp_head());
                end
                n_chk++;
            end
            if (IM_outRSPVALID && IM_outRSPADDR == 32'h14) begin
                hit++;
                if (IM_outRSPINST !== d) begin n_fail++; $display("FAIL load_visible got=%h exp=%h", IM_outRSPINST, d); end
                n_chk++;
            end
            tick();
        end
        if (hit != 1) begin n_fail++; $display("FAIL load_fetch_count got=%0d exp=1", hit); end
        n_chk++;
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                IM_inREQVALID = ($urandom_range(0, 3) != 0);
                IM_inREQADDR  = 32'($urandom_range(0, 63)) << 2;
                if ($urandom_range(0, 9) == 0) begin
                    b = $urandom_range(0, 21);
                    b = (b < 2) ? b : b + 10;
                    IM_inREQADDR = IM_inREQADDR ^ (32'h1 << b);
                end
                IM_inRSPREADY = ($urandom_range(0, 3) != 0);
                IM_inFLUSH    = ($urandom_range(0, 19) == 0);
                IM_inLOADEN   = ($urandom_range(0, 29) == 0);
                IM_inLOADADDR = DL'($urandom_range(0, 63));
                IM_inLOADDATA = $urandom;
            end else begin
                idle_inputs();
            end
            #1;
            if (IM_outREQREADY !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, IM_outREQREADY, exp_ready()); end
            if (IM_outRSPVALID !== exp_rv()) begin n_fail++; $display("FAIL rnd_rspvalid cyc=%0d got=%b exp=%b", cyc, IM_outRSPVALID, exp_rv()); end
            n_chk += 2;
            if (exp_rv()) begin
                if ({IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR} !== exp_head()) begin
                    n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, {IM_outRSPINST, IM_outRSPADDR, IM_outRSPERR}, exp_head());
                end
                n_chk++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_back_to_back();
        test_stall();
        test_flush();
        test_error();
        test_reset_mid();
        test_load_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
